ps2_kbd_tx: RTL

PS/2 device-side keyboard transmitter: serialises queued set-2 scancode bytes onto the PS/2 clock/data pair as a keyboard would. It is the sending end of the PS/2 receive path, used for on-board keyboard emulation and loopback. It generates the PS/2 clock, honours host inhibit (clock held low by the host), and retries any byte that was aborted.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_byte_fifo.sv | 62 ++++++
 rtl/ps2_kbd_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, frame constants and parity helper
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      LOW   = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } ps2_state_e;

   localparam int   FRAME_BITS = 11;
   localparam logic START      = 1'b0;
   localparam logic STOP       = 1'b1;

   // Odd parity: data ones plus the parity bit add up to an odd number.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - show-ahead byte FIFO shared by the PS/2 transmit and receive paths
module ps2_byte_fifo #(
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = 1;
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = DEPTH[FIFO_DEPTH_LOG2:0];

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;
   logic                       do_push;
   logic                       do_pop;

   // A pop frees the slot in the same cycle, so a push alongside a pop is taken even when full.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Storage array; contents are only meaningful below the occupancy count, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 keyboard-side byte transmitter; PS2_KBD_TX_ABORT_CNT_EN adds abort_cnt
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV         = 2000,
   parameter int IDLE_CYCLES     = 4000,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       sent
`ifdef PS2_KBD_TX_ABORT_CNT_EN
   ,
   output logic [7:0] abort_cnt
`endif
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = 1;
   localparam logic [DIV_W-1:0]  MASK_CYC  = 2;
   localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(IDLE_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = 1;
   localparam logic [3:0]        LAST_BIT  = 4'(FRAME_BITS - 1);

   ps2_state_e              state;
   ps2_state_e              state_next;
   logic                    clk_meta;
   logic                    clk_s;
   logic                    dat_meta;
   logic                    dat_s;
   logic [DIV_W-1:0]        div_cnt;
   logic [IDLE_W-1:0]       idle_cnt;
   logic [3:0]              bit_idx;
   logic [FRAME_BITS-1:0]   frame_q;
   logic [7:0]              fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    idle_ok;
   logic                    div_done;
   logic                    inhibit;

   assign tx_ready  = !fifo_full;
   assign fifo_push = tx_valid && tx_ready;

   ps2_byte_fifo #(
      .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Two-flop synchronisers for the open-collector lines; idle level is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta <= 1'b1;
         clk_s    <= 1'b1;
         dat_meta <= 1'b1;
         dat_s    <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_s    <= clk_meta;
         dat_meta <= ps2_dat_in;
         dat_s    <= dat_meta;
      end
   end

   // The first two clocks after releasing the clock still show our own low level through
   // the synchroniser, so the host-inhibit check ignores them. The stop bit is never aborted.
   assign idle_ok  = (idle_cnt == IDLE_DONE);
   assign div_done = (div_cnt == DIV_LAST);
   assign inhibit  = !clk_s && (bit_idx != LAST_BIT) && (div_cnt >= MASK_CYC);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (idle_ok && !fifo_empty) state_next = SETUP;
         SETUP:   if (inhibit) state_next = ABORT;
                  else if (div_done) state_next = LOW;
         LOW:     if (div_done) state_next = (bit_idx == LAST_BIT) ? DONE : SETUP;
         DONE:    state_next = IDLE;
         ABORT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Half-period timer, bit index, bus-idle timer and the latched frame image.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= '0;
         idle_cnt <= '0;
         bit_idx  <= '0;
         frame_q  <= '1;
      end else begin
         if ((state == SETUP || state == LOW) && state_next == state) begin
            div_cnt <= div_cnt + DIV_ONE;
         end else begin
            div_cnt <= '0;
         end

         if (state != IDLE || !(clk_s && dat_s)) begin
            idle_cnt <= '0;
         end else if (!idle_ok) begin
            idle_cnt <= idle_cnt + IDLE_ONE;
         end

         if (state == IDLE) begin
            bit_idx <= '0;
         end else if (state == LOW && div_done && bit_idx != LAST_BIT) begin
            bit_idx <= bit_idx + 4'd1;
         end

         if (state == IDLE && state_next == SETUP) begin
            frame_q <= {STOP, odd_parity(fifo_head), fifo_head, START};
         end
      end
   end

   // Line drive and status; a detected inhibit releases the data line in the same cycle.
   always_comb begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      busy       = 1'b0;
      sent       = 1'b0;
      fifo_pop   = 1'b0;
      case (state)
         SETUP: begin
            busy       = 1'b1;
            ps2_dat_oe = !inhibit && !frame_q[bit_idx];
         end
         LOW: begin
            busy       = 1'b1;
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = !frame_q[bit_idx];
         end
         DONE: begin
            busy     = 1'b1;
            sent     = 1'b1;
            fifo_pop = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

`ifdef PS2_KBD_TX_ABORT_CNT_EN
   // Saturating count of aborted frames, cleared only by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         abort_cnt <= '0;
      end else if (state_next == ABORT && state != ABORT && abort_cnt != 8'hFF) begin
         abort_cnt <= abort_cnt + 8'd1;
      end
   end
`else
   // No abort statistics in this build.
`endif

endmodule
